// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round
// Normalise-and-round back end of the single-precision multiplier.
// Stage 1 aligns the 48-bit mantissa product and extracts guard/sticky.
// Stage 2 rounds to nearest-even, applies range limits and packs the
// IEEE-754 word. Both stages use a valid/ready handshake so the result
// consumer can stall the pipeline without beats being lost or repeated.
// The 23-bit fraction packing assumes N = 24 (single precision).

module fp_mul_norm_round #(
    parameter int N  = 24,
    parameter int EW = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EW-1:0] in_exp,
    input  logic [2*N-1:0]       in_prod,
    input  logic                 in_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_ovf,
    output logic                 out_unf
);

    localparam int PW = 2 * N;
    localparam int XW = EW + 2;

    // Exponent limits are compared as signed values so that negative
    // exponent sums land in the underflow branch.
    localparam logic signed [XW-1:0] EXP_INF  = XW'(255);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    // Pipeline control.
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    // Stage 1 registers.
    logic [N-1:0]        s1_frac;
    logic                s1_guard;
    logic                s1_sticky;
    logic                s1_sign;
    logic                s1_zero;
    logic signed [EW:0]  s1_exp;

    // Normalisation results feeding stage 1.
    logic [N-1:0]        norm_frac;
    logic                norm_guard;
    logic                norm_sticky;
    logic signed [EW:0]  norm_exp;

    // Rounding results feeding stage 2.
    logic                round_up;
    logic [N:0]          sum_w;
    logic signed [XW-1:0] rnd_exp;
    logic [22:0]         rnd_frac;
    logic [31:0]         sel_result;
    logic                sel_ovf;
    logic                sel_unf;

    // A stage may advance when it is empty or the stage below it is moving.
    // in_ready depends only on out_ready and the valid bits, never on in_valid.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Align the product so the leading one sits at the top of a 24-bit
    // mantissa; a product >= 2.0 takes the upper window and bumps the exponent.
    always_comb begin
        norm_frac   = in_prod[PW-2:N-1];
        norm_guard  = in_prod[N-2];
        norm_sticky = |in_prod[N-3:0];
        norm_exp    = {in_exp[EW-1], in_exp};
        if (in_prod[PW-1]) begin
            norm_frac   = in_prod[PW-1:N];
            norm_guard  = in_prod[N-1];
            norm_sticky = |in_prod[N-2:0];
            norm_exp    = {in_exp[EW-1], in_exp} + (EW+1)'(1);
        end
    end

    // Stage 1 register: valid follows every advance, data loads only with a beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_frac   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_exp    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_frac   <= norm_frac;
                s1_guard  <= norm_guard;
                s1_sticky <= norm_sticky;
                s1_sign   <= in_sign;
                s1_zero   <= in_zero;
                s1_exp    <= norm_exp;
            end
        end
    end

    // Round to nearest, ties to even; a carry out of the mantissa means the
    // value became exactly 2.0, so the fraction clears and the exponent bumps.
    always_comb begin
        round_up = s1_guard & (s1_sticky | s1_frac[0]);
        sum_w    = {1'b0, s1_frac} + {{N{1'b0}}, round_up};
        rnd_exp  = {s1_exp[EW], s1_exp} + {{(XW-1){1'b0}}, sum_w[N]};
        rnd_frac = sum_w[N] ? 23'd0 : sum_w[N-2 -: 23];
    end

    // Pick the packed result: zero wins, then overflow, then flush-to-zero.
    always_comb begin
        sel_result = {s1_sign, 31'd0};
        sel_ovf    = 1'b0;
        sel_unf    = 1'b0;
        if (s1_zero) begin
            sel_result = {s1_sign, 31'd0};
        end else if (rnd_exp >= EXP_INF) begin
            sel_result = {s1_sign, 8'hFF, 23'd0};
            sel_ovf    = 1'b1;
        end else if (rnd_exp <= EXP_ZERO) begin
            sel_result = {s1_sign, 31'd0};
            sel_unf    = 1'b1;
        end else begin
            sel_result = {s1_sign, rnd_exp[7:0], rnd_frac};
        end
    end

    // Stage 2 register doubles as the output register; it holds while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid   <= 1'b0;
            out_result <= 32'h0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= sel_result;
                out_ovf    <= sel_ovf;
                out_unf    <= sel_unf;
            end
        end
    end

    // The output valid is simply the stage 2 occupancy.
    always_comb begin
        out_valid = s2_valid;
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round
// Scoreboard bench: expected words are queued as beats are accepted and
// popped when the DUT hands a result over the output handshake.

module tb_fp_mul_norm_round;

    localparam int N  = 24;
    localparam int EW = 10;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sign = 1'b0;
    logic signed [EW-1:0] in_exp = '0;
    logic [2*N-1:0]       in_prod = '0;
    logic                 in_zero = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          out_result;
    logic                 out_ovf;
    logic                 out_unf;

    int vectors = 0;
    int miscompares = 0;

    // Each entry is {ovf, unf, result}.
    logic [33:0] exp_q[$];

    fp_mul_norm_round #(.N(N), .EW(EW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference: keep the top 24 bits of the normalised product and compare
    // the discarded tail against one half ULP.
    function automatic logic [33:0] model(input logic sign, input int exp_sum,
                                          input logic [47:0] prod, input logic zero);
        logic [24:0] m;
        logic [23:0] rem;
        int e;
        if (zero) return {2'b00, sign, 31'd0};
        if (prod[47]) begin
            m   = {1'b0, prod[47:24]};
            rem = prod[23:0];
            e   = exp_sum + 1;
        end else begin
            m   = {1'b0, prod[46:23]};
            rem = {prod[22:0], 1'b0};
            e   = exp_sum;
        end
        if (rem > 24'h800000 || (rem == 24'h800000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, sign, 31'd0};
        return {2'b00, sign, e[7:0], m[22:0]};
    endfunction

    // Present a beat on the input port.
    task automatic drive(input logic sign, input int exp_sum, input logic [47:0] prod,
                         input logic zero);
        in_valid = 1'b1;
        in_sign  = sign;
        in_exp   = EW'(exp_sum);
        in_prod  = prod;
        in_zero  = zero;
    endtask

    // Advance one clock; report what the handshakes looked like before the edge.
    task automatic step(output bit fired, output bit valid, output logic [33:0] obs,
                        output bit accepted, output bit rdy);
        @(negedge clk);
        valid    = out_valid;
        fired    = out_valid && out_ready;
        obs      = {out_ovf, out_unf, out_result};
        accepted = in_valid && in_ready;
        rdy      = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (out_result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_result: got %h expected 00000000", out_result);
        end
        vectors++;
        if ({out_ovf, out_unf} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 00", {out_ovf, out_unf});
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        logic        t_sign[11];
        int          t_exp[11];
        logic [47:0] t_prod[11];
        logic        t_zero[11];
        logic [33:0] t_res[11];
        bit f, v, a, r;
        logic [33:0] o, e;
        // 1.0 x 1.0, 1.5 x 1.5 both signs, rounding ties and carry, range edges, zero
        t_sign[0]  = 0; t_exp[0]  = 127; t_prod[0]  = 48'h400000000000; t_zero[0]  = 0; t_res[0]  = {2'b00, 32'h3F800000};
        t_sign[1]  = 0; t_exp[1]  = 127; t_prod[1]  = 48'h900000000000; t_zero[1]  = 0; t_res[1]  = {2'b00, 32'h40100000};
        t_sign[2]  = 1; t_exp[2]  = 127; t_prod[2]  = 48'h900000000000; t_zero[2]  = 0; t_res[2]  = {2'b00, 32'hC0100000};
        t_sign[3]  = 0; t_exp[3]  = 127; t_prod[3]  = 48'h400000400000; t_zero[3]  = 0; t_res[3]  = {2'b00, 32'h3F800000};
        t_sign[4]  = 0; t_exp[4]  = 127; t_prod[4]  = 48'h400000C00000; t_zero[4]  = 0; t_res[4]  = {2'b00, 32'h3F800002};
        t_sign[5]  = 0; t_exp[5]  = 127; t_prod[5]  = 48'h7FFFFFC00000; t_zero[5]  = 0; t_res[5]  = {2'b00, 32'h40000000};
        t_sign[6]  = 0; t_exp[6]  = 254; t_prod[6]  = 48'h800000000000; t_zero[6]  = 0; t_res[6]  = {2'b10, 32'h7F800000};
        t_sign[7]  = 0; t_exp[7]  = 0;   t_prod[7]  = 48'h400000000000; t_zero[7]  = 0; t_res[7]  = {2'b01, 32'h00000000};
        t_sign[8]  = 1; t_exp[8]  = 127; t_prod[8]  = 48'h400000000000; t_zero[8]  = 1; t_res[8]  = {2'b00, 32'h80000000};
        t_sign[9]  = 0; t_exp[9]  = 253; t_prod[9]  = 48'h800000000000; t_zero[9]  = 0; t_res[9]  = {2'b00, 32'h7F000000};
        t_sign[10] = 0; t_exp[10] = 1;   t_prod[10] = 48'h400000000000; t_zero[10] = 0; t_res[10] = {2'b00, 32'h00800000};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(t_sign[i], t_exp[i], t_prod[i], t_zero[i]);
            step(f, v, o, a, r);
            vectors++;
            if (!a) begin
                miscompares++;
                $display("[TB] FAIL directed_accept[%0d]: got in_ready=%b expected 1", i, r);
            end else begin
                exp_q.push_back(t_res[i]);
            end
            in_valid = 1'b0;
            step(f, v, o, a, r);
            vectors++;
            if (v) begin
                miscompares++;
                $display("[TB] FAIL directed_latency[%0d]: got out_valid=1 after 1 cycle expected 0", i);
            end
            step(f, v, o, a, r);
            vectors++;
            if (!f) begin
                miscompares++;
                $display("[TB] FAIL directed_valid[%0d]: got out_valid=0 after 2 cycles expected 1", i);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL directed_extra[%0d]: got %h expected no output", i, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, o, e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit f, v, a, r;
        logic [33:0] o, e;
        logic [47:0] p;
        logic s, z;
        int x;
        int sent = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 24) begin
                p = {16'($urandom), $urandom};
                if (p[47:46] == 2'b00) p[46] = 1'b1;
                s = 1'($urandom);
                z = ($urandom_range(0, 9) == 0);
                x = int'($urandom_range(0, 320)) - 30;
                drive(s, x, p, z);
            end else begin
                in_valid = 1'b0;
            end
            step(f, v, o, a, r);
            vectors++;
            if (r !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", cyc, r);
            end
            if (a) begin
                exp_q.push_back(model(s, x, p, z));
                sent++;
            end
            if (f) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_extra: got %h expected no output", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_result: got %h expected %h", o, e);
                    end
                end
            end
            if (sent == 24 && exp_q.size() == 0) break;
        end
        vectors++;
        if (exp_q.size() != 0 || sent != 24) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain: got %0d sent, %0d pending expected 24 sent, 0 pending",
                     sent, exp_q.size());
        end
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit f, v, a, r;
        logic [33:0] o, e;
        logic [47:0] bp_prod[5];
        int sent = 0;
        int got = 0;
        for (int i = 0; i < 5; i++) bp_prod[i] = 48'h400000000000 + (48'(i + 1) << 24);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 5) drive(1'b0, 100 + sent, bp_prod[sent], 1'b0);
            else in_valid = 1'b0;
            out_ready = (cyc >= 4);
            step(f, v, o, a, r);
            if (cyc < 4) begin
                vectors++;
                if (r !== (sent < 2)) begin
                    miscompares++;
                    $display("[TB] FAIL bp_in_ready[%0d]: got %b expected %b", cyc, r, (sent < 2));
                end
            end
            if (cyc == 3) begin
                vectors++;
                if (!v) begin
                    miscompares++;
                    $display("[TB] FAIL bp_stall_valid: got out_valid=0 expected 1");
                end
            end
            if (cyc < 4 && v) begin
                vectors++;
                if (exp_q.size() == 0 || o !== exp_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", cyc, o,
                             (exp_q.size() == 0) ? 34'h0 : exp_q[0]);
                end
            end
            if (cyc == 4) begin
                vectors++;
                if (r !== 1'b1 || !a) begin
                    miscompares++;
                    $display("[TB] FAIL bp_release_accept: got in_ready=%b expected 1", r);
                end
            end
            if (a) begin
                exp_q.push_back(model(1'b0, 100 + sent, bp_prod[sent], 1'b0));
                sent++;
            end
            if (f) begin
                got++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_extra: got %h expected no output", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL bp_order: got %h expected %h", o, e);
                    end
                end
            end
            if (sent == 5 && exp_q.size() == 0 && cyc > 4) break;
        end
        vectors++;
        if (got != 5 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d results expected 5", got);
        end
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_stream();
        bit f, v, a, r;
        logic [33:0] o, e;
        out_ready = 1'b1;
        drive(1'b0, 127, 48'h900000000000, 1'b0);
        step(f, v, o, a, r);
        drive(1'b1, 127, 48'h900000000000, 1'b0);
        step(f, v, o, a, r);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (out_result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midrst_result: got %h expected 00000000", out_result);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready);
        end
        exp_q.delete();
        step(f, v, o, a, r);
        rstn = 1'b1;
        step(f, v, o, a, r);
        vectors++;
        if (v) begin
            miscompares++;
            $display("[TB] FAIL midrst_stale: got out_valid=1 expected 0");
        end
        drive(1'b0, 130, 48'h400000C00000, 1'b0);
        step(f, v, o, a, r);
        if (a) exp_q.push_back({2'b00, 32'h41000002});
        in_valid = 1'b0;
        step(f, v, o, a, r);
        vectors++;
        if (v) begin
            miscompares++;
            $display("[TB] FAIL midrst_latency: got out_valid=1 after 1 cycle expected 0");
        end
        step(f, v, o, a, r);
        vectors++;
        if (!f || exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_post: got valid=%b pending=%0d expected valid=1 pending=1",
                     f, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL midrst_post_result: got %h expected %h", o, e);
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog against a hung handshake.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
